bcd_counter_fnd_ctrl: RTL

- Parametrised N-digit BCD up/down counter with built-in tick prescaler and multiplexed 7-segment (FND) scan driver.
- Generalises the fixed 4-digit 0..9999 counter/FND pair: digit count, count rate and scan rate are parameters. Adds synchronous parallel load and a wrap pulse.
- Sits under the board top level, driving fnd_com/fnd_data directly from clk.

---
 rtl/bcd_counter_fnd_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_fnd_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_counter_fnd_ctrl
//
// N-digit BCD up/down counter with a built-in tick prescaler and a
// multiplexed common-anode 7-segment (FND) scan driver.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   defined   -> leading zero digits (never digit 0) are driven blank (8'hFF)
//   undefined -> every digit is always displayed, leading zeros included
//
// Parameters:
//   DIGITS   number of BCD digits / FND commons (1..8)
//   CLK_HZ   input clock frequency
//   COUNT_HZ count tick rate  (TICK_DIV = CLK_HZ/COUNT_HZ, >= 2)
//   SCAN_HZ  digit-advance rate (SCAN_DIV = CLK_HZ/SCAN_HZ, >= 2)
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   enable     1 = prescaler runs, counter advances on ticks
//   clear      synchronous clear of counter and tick prescaler
//   mode       0 = count up, 1 = count down (sampled on tick cycles only)
//   load       synchronous parallel load strobe
//   load_bcd   load value, digit k at [4k+3:4k]; digits >9 stored as 9
//   count_bcd  current count (registered)
//   wrap       one-cycle pulse when the count wraps
//   fnd_com    one-cold digit select (0 = digit on)
//   fnd_data   active-low segments {dp,g,f,e,d,c,b,a}; dp always off
// ---------------------------------------------------------------------------
module bcd_counter_fnd_ctrl #(
    parameter int DIGITS   = 4,
    parameter int CLK_HZ   = 100_000_000,
    parameter int COUNT_HZ = 10,
    parameter int SCAN_HZ  = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_bcd,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [DIGITS-1:0]     fnd_com,
    output logic [7:0]            fnd_data
);

    localparam int TICK_DIV = CLK_HZ / COUNT_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CW       = 4 * DIGITS;
    localparam int TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    // Elaboration-time parameter sanity
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_fnd_ctrl: DIGITS must be 1..8");
    end
    if (TICK_DIV < 2) begin : g_bad_tick
        $error("bcd_counter_fnd_ctrl: CLK_HZ/COUNT_HZ must be >= 2");
    end
    if (SCAN_DIV < 2) begin : g_bad_scan
        $error("bcd_counter_fnd_ctrl: CLK_HZ/SCAN_HZ must be >= 2");
    end

    // -----------------------------------------------------------------------
    // BCD helper functions
    // -----------------------------------------------------------------------

    // Ripple-carry BCD increment; all-nines rolls over to zero.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    r[4*k +: 4] = 4'd0;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // Ripple-borrow BCD decrement; zero rolls under to all nines.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (v[4*k +: 4] == 4'd0) begin
                    r[4*k +: 4] = 4'd9;
                end else begin
                    r[4*k +: 4] = v[4*k +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*k +: 4] = v[4*k +: 4];
            end
        end
        return r;
    endfunction

    // True when every digit is 9 (increment will wrap).
    function automatic logic bcd_all_nines(input logic [CW-1:0] v);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            r = r & (v[4*k +: 4] == 4'd9);
        end
        return r;
    endfunction

    // True when every digit is 0 (decrement will wrap).
    function automatic logic bcd_all_zero(input logic [CW-1:0] v);
        logic r;
        r = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            r = r & (v[4*k +: 4] == 4'd0);
        end
        return r;
    endfunction

    // Clamp any non-BCD nibble to 9 so the count register stays legal.
    function automatic logic [CW-1:0] bcd_saturate(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
        end
        return r;
    endfunction

    // Common-anode segment pattern {dp,g,f,e,d,c,b,a}, active low, dp off.
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0:    r = 8'hC0;
            4'd1:    r = 8'hF9;
            4'd2:    r = 8'hA4;
            4'd3:    r = 8'hB0;
            4'd4:    r = 8'h99;
            4'd5:    r = 8'h92;
            4'd6:    r = 8'h82;
            4'd7:    r = 8'hF8;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h90;
            default: r = 8'hFF;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_next_s;
    logic              wrap_r;
    logic              wrap_next_s;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic [IDX_W-1:0]  scan_idx_r;
    logic [3:0]        digit_s;
    logic              blank_s;
    logic [DIGITS-1:0] fnd_com_r;
    logic [7:0]        fnd_data_r;

    assign tick_s = enable & (tick_cnt_r == TICK_LAST);

    // Tick prescaler: runs only while enabled, holds while paused so the
    // period resumes where it left off; clear restarts it. A load does not
    // disturb the prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (clear) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (enable) begin
            if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_r <= {TICK_W{1'b0}};
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
        end else begin
            tick_cnt_r <= tick_cnt_r;
        end
    end

    // Counter next state, priority clear > load > tick.
    always_comb begin
        count_next_s = count_r;
        wrap_next_s  = 1'b0;
        if (clear) begin
            count_next_s = {CW{1'b0}};
        end else if (load) begin
            count_next_s = bcd_saturate(load_bcd);
        end else if (tick_s) begin
            if (mode) begin
                count_next_s = bcd_dec(count_r);
                wrap_next_s  = bcd_all_zero(count_r);
            end else begin
                count_next_s = bcd_inc(count_r);
                wrap_next_s  = bcd_all_nines(count_r);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and wrap registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= wrap_next_s;
        end
    end

    // Free-running scan prescaler and digit index; ignores enable and clear
    // so the display keeps refreshing while the counter is paused.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            scan_idx_r <= {IDX_W{1'b0}};
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
            scan_idx_r <= (scan_idx_r == IDX_LAST) ? {IDX_W{1'b0}}
                                                   : scan_idx_r + IDX_W'(1);
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            scan_idx_r <= scan_idx_r;
        end
    end

    // Select the digit currently being scanned.
    always_comb begin
        digit_s = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            digit_s = (IDX_W'(k) == scan_idx_r) ? count_r[4*k +: 4] : digit_s;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every higher digit are zero; digit 0 is
    // never blanked so a zero count still shows a single "0".
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        blank_s     = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            higher_zero = higher_zero & (count_r[4*k +: 4] == 4'd0);
            blank_s     = ((k != 0) && (IDX_W'(k) == scan_idx_r)) ? higher_zero
                                                                  : blank_s;
        end
    end
`else
    // Leading zeros are displayed.
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Registered FND drive, one clock behind the scan index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fnd_com_r  <= {DIGITS{1'b1}};
            fnd_data_r <= 8'hFF;
        end else begin
            fnd_com_r  <= ~(DIGITS'(1) << scan_idx_r);
            fnd_data_r <= blank_s ? 8'hFF : seg7(digit_s);
        end
    end

    assign count_bcd = count_r;
    assign wrap      = wrap_r;
    assign fnd_com   = fnd_com_r;
    assign fnd_data  = fnd_data_r;

endmodule
